// File: rtl/multi_mode_freq_divider.sv
// Purpose: multi-channel programmable clock-enable divider producing one-cycle ticks and square waves.
// Latency: a load takes effect on its write edge; the first tick is registered D+1 enabled edges later.
// Backpressure: none; en[i] low freezes channel i, and writes are always accepted.
//
// Ports:
//   clk, rst                  rising-edge clock, asynchronous active-high reset
//   en[CHANNELS]              per-channel count enable
//   wr_en/wr_ch/wr_div/wr_mode/wr_restart  shared configuration write port
//   tick/wave/run/pend        per-channel registered status outputs
module multi_mode_freq_divider #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4,
    localparam int CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] en,
    input  logic                wr_en,
    input  logic [CW-1:0]       wr_ch,
    input  logic [WIDTH-1:0]    wr_div,
    input  logic [1:0]          wr_mode,
    input  logic                wr_restart,
    output logic [CHANNELS-1:0] tick,
    output logic [CHANNELS-1:0] wave,
    output logic [CHANNELS-1:0] run,
    output logic [CHANNELS-1:0] pend
);

    localparam logic [1:0] MODE_PULSE = 2'b00;
    localparam logic [1:0] MODE_SQ    = 2'b01;
    localparam logic [1:0] MODE_ONE   = 2'b10;

    // Mode 11 is stored as 00 so the counting logic only ever sees three modes.
    logic [1:0] mode_in;
    assign mode_in = (wr_mode == 2'b11) ? MODE_PULSE : wr_mode;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [WIDTH-1:0] cnt_q, cnt_n;
        logic [WIDTH-1:0] act_div_q, act_div_n;
        logic [WIDTH-1:0] shd_div_q, shd_div_n;
        logic [1:0]       act_mode_q, act_mode_n;
        logic [1:0]       shd_mode_q, shd_mode_n;
        logic             done_q, done_n;
        logic             wave_q, wave_n;
        logic             tick_q, tick_n;
        logic             pend_q, pend_n;
        logic             run_q, run_n;
        logic             wr_hit;
        logic             terminal;

        // Out-of-range channel numbers never compare equal to any instance index.
        assign wr_hit   = wr_en && (wr_ch == CW'(i));
        assign terminal = en[i] && run_q && (cnt_q == '0);

        always_comb begin
            cnt_n      = cnt_q;
            act_div_n  = act_div_q;
            act_mode_n = act_mode_q;
            shd_div_n  = shd_div_q;
            shd_mode_n = shd_mode_q;
            done_n     = done_q;
            wave_n     = wave_q;
            pend_n     = pend_q;
            tick_n     = 1'b0;

            if (en[i] && run_q) begin
                if (cnt_q != '0) begin
                    cnt_n = cnt_q - 1'b1;
                end else begin
                    tick_n = 1'b1;
                    if (act_mode_q == MODE_SQ) begin
                        wave_n = ~wave_q;
                    end
                    if (pend_q) begin
                        // Shadowed setting takes over exactly at the period boundary.
                        act_div_n  = shd_div_q;
                        act_mode_n = shd_mode_q;
                        cnt_n      = shd_div_q;
                        pend_n     = 1'b0;
                        if (shd_mode_q != MODE_SQ) begin
                            wave_n = 1'b0;
                        end
                    end else if (act_mode_q == MODE_ONE) begin
                        done_n = 1'b1;
                    end else begin
                        cnt_n = act_div_q;
                    end
                end
            end

            if (wr_hit) begin
                if (!run_q || wr_restart || terminal) begin
                    act_div_n  = wr_div;
                    act_mode_n = mode_in;
                    cnt_n      = wr_div;
                    done_n     = 1'b0;
                    pend_n     = 1'b0;
                    if (wr_restart || !terminal) begin
                        wave_n = 1'b0;
                        tick_n = 1'b0;
                    end else if (mode_in != MODE_SQ) begin
                        // Write coinciding with the terminal count: old period's
                        // tick still fires, wave keeps its toggle only in square mode.
                        wave_n = 1'b0;
                    end
                end else begin
                    shd_div_n  = wr_div;
                    shd_mode_n = mode_in;
                    pend_n     = 1'b1;
                end
            end

            // A zero divisor parks the channel with wave low.
            if (act_div_n == '0) begin
                wave_n = 1'b0;
            end
            run_n = (act_div_n != '0) && !done_n;
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_q      <= '0;
                act_div_q  <= '0;
                act_mode_q <= '0;
                shd_div_q  <= '0;
                shd_mode_q <= '0;
                done_q     <= 1'b0;
                wave_q     <= 1'b0;
                tick_q     <= 1'b0;
                pend_q     <= 1'b0;
                run_q      <= 1'b0;
            end else begin
                cnt_q      <= cnt_n;
                act_div_q  <= act_div_n;
                act_mode_q <= act_mode_n;
                shd_div_q  <= shd_div_n;
                shd_mode_q <= shd_mode_n;
                done_q     <= done_n;
                wave_q     <= wave_n;
                tick_q     <= tick_n;
                pend_q     <= pend_n;
                run_q      <= run_n;
            end
        end

        assign tick[i] = tick_q;
        assign wave[i] = wave_q;
        assign run[i]  = run_q;
        assign pend[i] = pend_q;
    end

endmodule

// File: tb/tb_multi_mode_freq_divider.sv
module tb_multi_mode_freq_divider;

    localparam int WIDTH = 16;
    localparam int CH    = 3;   // three channels so wr_ch=3 is an out-of-range select

    logic          clk;
    logic          rst;
    logic [CH-1:0] en;
    logic          wr_en;
    logic [1:0]    wr_ch;
    logic [WIDTH-1:0] wr_div;
    logic [1:0]    wr_mode;
    logic          wr_restart;
    logic [CH-1:0] tick;
    logic [CH-1:0] wave;
    logic [CH-1:0] run;
    logic [CH-1:0] pend;

    int n_checks = 0;
    int n_fail   = 0;

    multi_mode_freq_divider #(.WIDTH(WIDTH), .CHANNELS(CH)) dut (
        .clk(clk), .rst(rst), .en(en),
        .wr_en(wr_en), .wr_ch(wr_ch), .wr_div(wr_div),
        .wr_mode(wr_mode), .wr_restart(wr_restart),
        .tick(tick), .wave(wave), .run(run), .pend(pend)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one rising edge and return at the following falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Called at a falling edge; the write is sampled on the next rising edge.
    task automatic do_write(input int ch, input int d, input int m, input bit rs);
        wr_en      = 1'b1;
        wr_ch      = 2'(ch);
        wr_div     = 16'(d);
        wr_mode    = 2'(m);
        wr_restart = rs;
        step();
        wr_en      = 1'b0;
        wr_restart = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        n_checks++;
        if ({tick, wave, run, pend} !== 12'b0) begin
            n_fail++;
            $display("FAIL reset_held got tick=%b wave=%b run=%b pend=%b exp all 0", tick, wave, run, pend);
        end
        rst = 1'b0;
        step();
        n_checks++;
        if ({tick, wave, run, pend} !== 12'b0) begin
            n_fail++;
            $display("FAIL reset_release got tick=%b wave=%b run=%b pend=%b exp all 0", tick, wave, run, pend);
        end
    endtask

    task automatic test_periodic();
        en = '1;
        do_write(0, 3, 0, 1'b1);
        n_checks++;
        if (run[0] !== 1'b1 || tick[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL periodic_load got run=%b tick=%b exp run=1 tick=0", run[0], tick[0]);
        end
        for (int c = 1; c <= 12; c++) begin
            step();
            n_checks++;
            if (tick[0] !== ((c % 4) == 0)) begin
                n_fail++;
                $display("FAIL periodic_tick c=%0d got %b exp %b", c, tick[0], (c % 4) == 0);
            end
            n_checks++;
            if (run[2:1] !== 2'b00 || tick[2:1] !== 2'b00) begin
                n_fail++;
                $display("FAIL periodic_others c=%0d got run=%b tick=%b exp 00/00", c, run[2:1], tick[2:1]);
            end
        end
    endtask

    task automatic test_wave();
        do_write(1, 4, 1, 1'b1);
        for (int c = 1; c <= 20; c++) begin
            step();
            n_checks++;
            if (tick[1] !== ((c % 5) == 0)) begin
                n_fail++;
                $display("FAIL wave_tick c=%0d got %b exp %b", c, tick[1], (c % 5) == 0);
            end
            n_checks++;
            if (wave[1] !== (((c / 5) % 2) == 1)) begin
                n_fail++;
                $display("FAIL wave_level c=%0d got %b exp %b", c, wave[1], ((c / 5) % 2) == 1);
            end
        end
    endtask

    task automatic test_zero_div();
        do_write(1, 0, 1, 1'b1);
        n_checks++;
        if (run[1] !== 1'b0 || wave[1] !== 1'b0 || tick[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_div got run=%b wave=%b tick=%b exp 0/0/0", run[1], wave[1], tick[1]);
        end
    endtask

    task automatic test_pend();
        do_write(0, 3, 0, 1'b1);          // c=0
        step();                           // c=1
        do_write(0, 9, 0, 1'b0);          // c=2, shadowed
        do_write(0, 1, 3, 1'b0);          // c=3, last write wins (mode 11 -> 00)
        n_checks++;
        if (pend[0] !== 1'b1 || tick[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL pend_set got pend=%b tick=%b exp 1/0", pend[0], tick[0]);
        end
        step();                           // c=4: old period ends
        n_checks++;
        if (tick[0] !== 1'b1 || pend[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL pend_apply got tick=%b pend=%b exp 1/0", tick[0], pend[0]);
        end
        for (int c = 5; c <= 10; c++) begin
            step();
            n_checks++;
            if (tick[0] !== ((c % 2) == 0) || pend[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL pend_new_period c=%0d got tick=%b pend=%b exp %b/0", c, tick[0], pend[0], (c % 2) == 0);
            end
        end
    endtask

    task automatic test_back_to_back();
        do_write(0, 3, 0, 1'b1);          // c=0
        step();
        step();
        step();                           // c=3, cnt=0
        do_write(0, 1, 0, 1'b0);          // c=4: write lands on terminal count
        n_checks++;
        if (tick[0] !== 1'b1 || pend[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_terminal got tick=%b pend=%b exp 1/0", tick[0], pend[0]);
        end
        step();
        n_checks++;
        if (tick[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_c5 got %b exp 0", tick[0]);
        end
        step();
        n_checks++;
        if (tick[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_c6 got %b exp 1", tick[0]);
        end
    endtask

    task automatic test_oneshot();
        do_write(2, 2, 2, 1'b1);
        n_checks++;
        if (run[2] !== 1'b1) begin
            n_fail++;
            $display("FAIL oneshot_run got %b exp 1", run[2]);
        end
        for (int c = 1; c <= 8; c++) begin
            step();
            n_checks++;
            if (tick[2] !== (c == 3) || run[2] !== (c < 3) || wave[2] !== 1'b0) begin
                n_fail++;
                $display("FAIL oneshot c=%0d got tick=%b run=%b wave=%b exp %b/%b/0", c, tick[2], run[2], wave[2], c == 3, c < 3);
            end
        end
        do_write(2, 2, 2, 1'b0);          // idle channel: applied immediately
        for (int c = 1; c <= 3; c++) begin
            step();
            n_checks++;
            if (tick[2] !== (c == 3)) begin
                n_fail++;
                $display("FAIL oneshot_rearm c=%0d got %b exp %b", c, tick[2], c == 3);
            end
        end
    endtask

    task automatic test_enable();
        do_write(0, 3, 0, 1'b1);          // c=0
        step();                           // cnt=2
        en[0] = 1'b0;
        do_write(3, 1, 0, 1'b1);          // frozen edge 1, out-of-range write
        n_checks++;
        if (pend !== 3'b000 || run[2] !== 1'b0 || run[0] !== 1'b1 || tick[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL bad_ch_write got pend=%b run=%b tick0=%b exp pend=000 run[2]=0 run[0]=1 tick0=0", pend, run, tick[0]);
        end
        for (int k = 2; k <= 5; k++) begin
            step();
            n_checks++;
            if (tick[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL enable_frozen k=%0d got %b exp 0", k, tick[0]);
            end
        end
        en[0] = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            step();
            n_checks++;
            if (tick[0] !== (c == 3)) begin
                n_fail++;
                $display("FAIL enable_resume c=%0d got %b exp %b", c, tick[0], c == 3);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_write(0, 3, 0, 1'b1);
        step();
        do_write(0, 5, 1, 1'b0);
        n_checks++;
        if (pend[0] !== 1'b1 || run[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_pre got pend=%b run=%b exp 1/1", pend[0], run[0]);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({tick, wave, run, pend} !== 12'b0) begin
            n_fail++;
            $display("FAIL rstmid_async got tick=%b wave=%b run=%b pend=%b exp all 0", tick, wave, run, pend);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            step();
            n_checks++;
            if ({tick, wave, run, pend} !== 12'b0) begin
                n_fail++;
                $display("FAIL rstmid_idle c=%0d got tick=%b wave=%b run=%b pend=%b exp all 0", c, tick, wave, run, pend);
            end
        end
    endtask

    initial begin
        rst        = 1'b1;
        en         = '0;
        wr_en      = 1'b0;
        wr_ch      = '0;
        wr_div     = '0;
        wr_mode    = '0;
        wr_restart = 1'b0;
        @(negedge clk);
        test_reset();
        test_periodic();
        test_wave();
        test_zero_div();
        test_pend();
        test_back_to_back();
        test_oneshot();
        test_enable();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multi_mode_freq_divider.md
Name: multi_mode_freq_divider

Overview:
- Multi-channel programmable clock-enable divider generating per-channel one-cycle ticks and square waves from clk.
- Divisors and modes are written through a shared write port.
- A divisor change on a running channel is shadowed and applied only at that channel's terminal count, so periods stay glitch-free.
- Sits between the system clock and timing consumers: baud ticks, display refresh, blinkers.

Parameters:
- WIDTH, 16, divisor/counter width per channel.
- CHANNELS, 4, number of independent divider channels (>=1).
- CW, max(1,$clog2(CHANNELS)), channel-select width (derived, not overridden).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- en  in  CHANNELS  per-channel count enable; when low, the channel freezes.
- wr_en  in  1  write strobe, sampled on rising clk.
- wr_ch  in  CW  target channel; values >= CHANNELS are ignored.
- wr_div  in  WIDTH  divisor D; period = D+1 enabled cycles; D=0 idles the channel.
- wr_mode  in  2  00 periodic pulse, 01 square wave, 10 one-shot, 11 treated as 00.
- wr_restart  in  1  with wr_en: apply immediately and restart, even if the channel is running.
- tick  out  CHANNELS  registered one-cycle pulse at each terminal count.
- wave  out  CHANNELS  registered square output; toggles at each terminal count in mode 01.
- run  out  CHANNELS  1 while the channel is counting (active D!=0 and not one-shot-done).
- pend  out  CHANNELS  1 while a shadowed write awaits its terminal count.

Behaviour:
- Per-channel state: cnt[WIDTH], act_div, act_mode, shd_div, shd_mode, done, wave, tick, pend.
- Reset (async, any time, including mid-count or mid-pending write):
  - All state is 0: every channel idle, all outputs 0.
  - Any pending write is discarded.
- Idle channel (act_div==0 or done):
  - tick=0; run=0.
  - wave holds 0 (one-shot leaves wave at 0).
- Counting, on each rising edge with en[i]=1 and run[i]=1:
  - If cnt!=0: cnt <= cnt-1 and tick <= 0.
  - If cnt==0 (terminal count): tick <= 1, and the following apply.
  - Mode 01: wave <= ~wave.
  - If pend: act <= shd, cnt <= shd_div, pend <= 0, wave <= 0 when the new mode is not 01.
  - Otherwise cnt <= act_div.
  - Mode 10: done <= 1 and cnt stays 0.
- Enable low: with en[i]=0, cnt, wave, pend and done hold; tick <= 0.
- Resulting timing with en high:
  - tick period is D+1 cycles with duty 1/(D+1).
  - wave period is 2(D+1) cycles with exactly 50% duty.
  - One-shot: a single tick D+1 enabled cycles after the load edge.
- Write to an idle channel, or any write with wr_restart=1, on that edge:
  - act_div <= wr_div, act_mode <= wr_mode, cnt <= wr_div.
  - wave <= 0, tick <= 0, done <= 0, pend <= 0.
  - Counting starts on the next edge.
- Write to a running channel without restart: shd <= wr_div/wr_mode and pend <= 1. The last write before the terminal count wins.
- Write and terminal count on the same edge for the same channel:
  - The write value is loaded directly as the new active setting (cnt <= wr_div); pend stays 0.
  - tick still fires for the old period.
- Applying D=0, immediately or from the shadow: the channel goes idle, wave <= 0.
- Writes with wr_ch >= CHANNELS: no effect on any channel.
- Channels are fully independent; a write affects only the selected channel.
- All outputs come directly from flops; there is no combinational path from inputs to outputs.

Test Plan:
- Reset, then a restart write to ch0 with D=3, mode 00, en high -> tick[0] high on cycles 4, 8, 12 after the load edge; run[0]=1; other channels stay 0.
- Restart write to ch1 with D=4, mode 01 -> wave[1] toggles every 5 cycles (period 10, 5 high / 5 low); tick[1] every 5 cycles.
- ch0 running D=3; non-restart write D=1 mid-period -> pend[0]=1 until the next tick; the old period completes, then tick every 2 cycles; pend[0] back to 0.
- ch2 one-shot with D=2 -> exactly one tick on the 3rd cycle; then run[2]=0 and no more ticks; a new write re-arms it.
- ch0 D=3 with en[0] held low for 5 cycles mid-count -> cnt frozen, tick delayed by exactly 5 cycles; wr_ch=CHANNELS is ignored.
- Assert rst mid-count while pend=1 -> all outputs 0 immediately; after release the channel is idle until rewritten.
